// File: rtl/bus_pkg.sv
// Shared definitions for the serial frame bus.
// Used by both the bus transmitter and the receiver nodes.
package bus_pkg;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 64;
    localparam int CRC_W      = 4;
    localparam int FRAME_BITS = 74;
    localparam int SHIFT_W    = ADDR_W + DATA_W;
    localparam int CNT_W      = 7;

    localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CRC,
        ST_STOP
    } bus_state_e;

    // Counter value at which a field's final bit is sampled.
    function automatic logic [CNT_W-1:0] field_last(
        input bus_state_e s
    );
        case (s)
            ST_ADDR: field_last = CNT_W'(ADDR_W - 1);
            ST_DATA: field_last = CNT_W'(DATA_W - 1);
            ST_CRC:  field_last = CNT_W'(CRC_W - 1);
            default: field_last = '0;
        endcase
    endfunction

endpackage

// File: rtl/bus_frame_receiver_if.sv
// Receiver-side bus and output-buffer handshake.
// master drives the serial bus and consumes frames.
interface bus_frame_receiver_if;
    import bus_pkg::*;

    logic              bus_in;
    logic              rx_ready;
    logic              rx_valid;
    logic [ADDR_W-1:0] rx_addr;
    logic [DATA_W-1:0] rx_data;
    logic              crc_err;
    logic              frame_err;
    logic              overflow;
    logic              busy;

    modport master (
        output bus_in,
        output rx_ready,
        input  rx_valid,
        input  rx_addr,
        input  rx_data,
        input  crc_err,
        input  frame_err,
        input  overflow,
        input  busy
    );

    modport slave (
        input  bus_in,
        input  rx_ready,
        output rx_valid,
        output rx_addr,
        output rx_data,
        output crc_err,
        output frame_err,
        output overflow,
        output busy
    );

endinterface

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 (x^4+x+1), MSB first, init 0.
// clear has priority over enable.
module crc4_serial
    import bus_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic fb;

    assign fb = crc[CRC_W-1] ^ bit_in;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/bus_frame_receiver.sv
// Serial frame receiver: deserialise, CRC-check, filter by
// address and hold one accepted frame in a valid/ready buffer.
module bus_frame_receiver
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] NODE_ADDR = 4'd1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bus_frame_receiver_if.slave  bus
);

    bus_state_e state, state_nx;

    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [SHIFT_W-1:0] sr;
    logic [CRC_W-1:0]   rx_crc;
    logic [CRC_W-1:0]   crc;

    logic last;
    logic shift_en;
    logic crc_en;
    logic crc_clr;
    logic crc_shift;
    logic stop_cyc;

    logic addr_hit;
    logic crc_ok;
    logic pop;

    logic pend_commit;
    logic pend_crc_err;
    logic pend_frame_err;

    crc4_serial u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (crc_clr),
        .enable  (crc_en),
        .bit_in  (bus.bus_in),
        .crc     (crc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        shift_en  = 1'b0;
        crc_en    = 1'b0;
        crc_clr   = 1'b0;
        crc_shift = 1'b0;
        stop_cyc  = 1'b0;
        last      = (cnt == field_last(state));
        case (state)
            ST_IDLE: begin
                crc_clr = 1'b1;
                if (bus.bus_in) begin
                    state_nx = ST_ADDR;
                end
            end
            ST_ADDR: begin
                shift_en = 1'b1;
                crc_en   = 1'b1;
                cnt_nx   = cnt + 1'b1;
                if (last) begin
                    cnt_nx   = '0;
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                shift_en = 1'b1;
                crc_en   = 1'b1;
                cnt_nx   = cnt + 1'b1;
                if (last) begin
                    cnt_nx   = '0;
                    state_nx = ST_CRC;
                end
            end
            ST_CRC: begin
                crc_shift = 1'b1;
                cnt_nx    = cnt + 1'b1;
                if (last) begin
                    cnt_nx   = '0;
                    state_nx = ST_STOP;
                end
            end
            ST_STOP: begin
                // A 1 here is a framing error, never a new start bit.
                stop_cyc = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign addr_hit = (sr[SHIFT_W-1 -: ADDR_W] == NODE_ADDR);
    assign crc_ok   = (rx_crc == crc);
    assign pop      = bus.rx_valid && bus.rx_ready;
    assign bus.busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr             <= '0;
            rx_crc         <= '0;
            pend_commit    <= 1'b0;
            pend_crc_err   <= 1'b0;
            pend_frame_err <= 1'b0;
        end else begin
            if (shift_en) begin
                sr <= {sr[SHIFT_W-2:0], bus.bus_in};
            end
            if (crc_shift) begin
                rx_crc <= {rx_crc[CRC_W-2:0], bus.bus_in};
            end
            pend_frame_err <= stop_cyc && bus.bus_in;
            pend_commit    <= stop_cyc && !bus.bus_in
                              && addr_hit && crc_ok;
            pend_crc_err   <= stop_cyc && !bus.bus_in
                              && addr_hit && !crc_ok;
        end
    end

    // sr is untouched in the IDLE cycle after STOP, so it is
    // still the finished frame when the pending commit lands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.rx_valid  <= 1'b0;
            bus.rx_addr   <= '0;
            bus.rx_data   <= '0;
            bus.crc_err   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.crc_err   <= pend_crc_err;
            bus.frame_err <= pend_frame_err;
            bus.overflow  <= pend_commit && bus.rx_valid && !pop;
            if (pend_commit && (!bus.rx_valid || pop)) begin
                bus.rx_valid <= 1'b1;
                bus.rx_addr  <= sr[SHIFT_W-1 -: ADDR_W];
                bus.rx_data  <= sr[DATA_W-1:0];
            end else if (pop) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Directed bench for bus_frame_receiver (NODE_ADDR=1).
// Bus driven and outputs sampled on the falling edge.
module tb_bus_frame_receiver;
    import bus_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    bus_frame_receiver_if bif();

    bus_frame_receiver #(.NODE_ADDR(4'd1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif)
    );

    always #5 clock = ~clock;

    task automatic send_frame(input logic [3:0] a, input logic [63:0] d,
                              input logic [3:0] c, input logic s,
                              input int nbits);
        logic [FRAME_BITS-1:0] f;
        f = {1'b1, a, d, c, s};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            bif.bus_in = f[FRAME_BITS-1-i];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bif.bus_in = 1'b0;
        end
    endtask

    task automatic test_reset;
        bif.bus_in   = 1'b0;
        bif.rx_ready = 1'b0;
        reset_n      = 1'b0;
        @(negedge clock);
        checks++;
        if (bif.rx_valid !== 1'b0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_vb got %b%b exp 00", bif.rx_valid, bif.busy);
        end
        checks++;
        if ({bif.crc_err, bif.frame_err, bif.overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b exp 000",
                     bif.crc_err, bif.frame_err, bif.overflow);
        end
        checks++;
        if (bif.rx_data !== 64'h0 || bif.rx_addr !== 4'h0) begin
            errors++;
            $display("FAIL reset_buf got %h/%h exp 0/0", bif.rx_addr, bif.rx_data);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_good_frame;
        bif.rx_ready = 1'b1;
        send_frame(4'd1, 64'h1, 4'h6, 1'b0, 74);
        checks++;
        if (bif.busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_busy got %b exp 1", bif.busy);
        end
        idle(1);
        checks++;
        if (bif.rx_valid !== 1'b0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_e73 got v%b b%b exp v0 b0", bif.rx_valid, bif.busy);
        end
        idle(1);
        checks++;
        if (bif.rx_valid !== 1'b1 || bif.rx_addr !== 4'd1 || bif.rx_data !== 64'h1) begin
            errors++;
            $display("FAIL t1_out got v%b a%h d%h exp v1 a1 d1",
                     bif.rx_valid, bif.rx_addr, bif.rx_data);
        end
        checks++;
        if ({bif.crc_err, bif.frame_err, bif.overflow} !== 3'b000) begin
            errors++;
            $display("FAIL t1_flags got %b%b%b exp 000",
                     bif.crc_err, bif.frame_err, bif.overflow);
        end
        idle(1);
        checks++;
        if (bif.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_pop got %b exp 0", bif.rx_valid);
        end
        bif.rx_ready = 1'b0;
        idle(2);
    endtask

    task automatic test_overflow;
        bif.rx_ready = 1'b0;
        send_frame(4'd1, 64'h0, 4'h5, 1'b0, 74);
        idle(2);
        checks++;
        if (bif.rx_valid !== 1'b1 || bif.rx_data !== 64'h0 || bif.overflow !== 1'b0) begin
            errors++;
            $display("FAIL t2_first got v%b d%h o%b exp v1 d0 o0",
                     bif.rx_valid, bif.rx_data, bif.overflow);
        end
        idle(3);
        send_frame(4'd1, 64'h0, 4'h5, 1'b0, 74);
        idle(2);
        checks++;
        if (bif.overflow !== 1'b1 || bif.rx_valid !== 1'b1 || bif.crc_err !== 1'b0) begin
            errors++;
            $display("FAIL t2_ovf got o%b v%b c%b exp o1 v1 c0",
                     bif.overflow, bif.rx_valid, bif.crc_err);
        end
        idle(1);
        checks++;
        if (bif.overflow !== 1'b0 || bif.rx_valid !== 1'b1 || bif.rx_data !== 64'h0) begin
            errors++;
            $display("FAIL t2_hold got o%b v%b d%h exp o0 v1 d0",
                     bif.overflow, bif.rx_valid, bif.rx_data);
        end
        bif.rx_ready = 1'b1;
        idle(1);
        checks++;
        if (bif.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL t2_pop got %b exp 0", bif.rx_valid);
        end
        bif.rx_ready = 1'b0;
        idle(2);
    endtask

    task automatic test_crc_err;
        send_frame(4'd1, 64'h1, 4'h7, 1'b0, 74);
        idle(2);
        checks++;
        if (bif.crc_err !== 1'b1 || bif.rx_valid !== 1'b0
            || bif.frame_err !== 1'b0 || bif.overflow !== 1'b0) begin
            errors++;
            $display("FAIL t3_crc got c%b v%b f%b o%b exp c1 v0 f0 o0",
                     bif.crc_err, bif.rx_valid, bif.frame_err, bif.overflow);
        end
        idle(1);
        checks++;
        if (bif.crc_err !== 1'b0) begin
            errors++;
            $display("FAIL t3_pulse got %b exp 0", bif.crc_err);
        end
        idle(2);
    endtask

    task automatic test_foreign_and_stop;
        send_frame(4'd2, 64'h1, 4'h9, 1'b0, 74);
        idle(2);
        checks++;
        if ({bif.rx_valid, bif.crc_err, bif.frame_err, bif.overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL t4_foreign got %b%b%b%b exp 0000",
                     bif.rx_valid, bif.crc_err, bif.frame_err, bif.overflow);
        end
        idle(2);
        send_frame(4'd2, 64'h1, 4'h9, 1'b1, 74);
        idle(1);
        checks++;
        if (bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_stop_busy got %b exp 0", bif.busy);
        end
        idle(1);
        checks++;
        if ({bif.frame_err, bif.crc_err, bif.overflow, bif.rx_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL t4_ferr got %b%b%b%b exp 1000",
                     bif.frame_err, bif.crc_err, bif.overflow, bif.rx_valid);
        end
        idle(1);
        checks++;
        if (bif.frame_err !== 1'b0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_after got f%b b%b exp f0 b0", bif.frame_err, bif.busy);
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        send_frame(4'd1, 64'h1, 4'h6, 1'b0, 31);
        @(negedge clock);
        reset_n    = 1'b0;
        bif.bus_in = 1'b0;
        @(negedge clock);
        checks++;
        if (bif.busy !== 1'b0 || bif.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL t5_abort got b%b v%b exp b0 v0", bif.busy, bif.rx_valid);
        end
        reset_n = 1'b1;
        idle(50);
        checks++;
        if ({bif.rx_valid, bif.crc_err, bif.frame_err, bif.overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL t5_quiet got %b%b%b%b exp 0000",
                     bif.rx_valid, bif.crc_err, bif.frame_err, bif.overflow);
        end
        send_frame(4'd1, 64'h1, 4'h6, 1'b0, 74);
        idle(2);
        checks++;
        if (bif.rx_valid !== 1'b1 || bif.rx_data !== 64'h1 || bif.rx_addr !== 4'd1) begin
            errors++;
            $display("FAIL t5_deliver got v%b a%h d%h exp v1 a1 d1",
                     bif.rx_valid, bif.rx_addr, bif.rx_data);
        end
        bif.rx_ready = 1'b1;
        idle(1);
        bif.rx_ready = 1'b0;
        idle(2);
    endtask

    task automatic test_back_to_back;
        bif.rx_ready = 1'b0;
        send_frame(4'd1, 64'h1, 4'h6, 1'b0, 74);
        send_frame(4'd1, 64'h0, 4'h5, 1'b0, 74);
        checks++;
        if (bif.rx_valid !== 1'b1 || bif.rx_data !== 64'h1) begin
            errors++;
            $display("FAIL t6_first got v%b d%h exp v1 d1", bif.rx_valid, bif.rx_data);
        end
        @(negedge clock);
        bif.bus_in   = 1'b0;
        bif.rx_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (bif.rx_valid !== 1'b1 || bif.rx_data !== 64'h0 || bif.overflow !== 1'b0) begin
            errors++;
            $display("FAIL t6_swap got v%b d%h o%b exp v1 d0 o0",
                     bif.rx_valid, bif.rx_data, bif.overflow);
        end
        bif.rx_ready = 1'b0;
        idle(1);
        checks++;
        if (bif.rx_valid !== 1'b1 || bif.overflow !== 1'b0) begin
            errors++;
            $display("FAIL t6_hold got v%b o%b exp v1 o0", bif.rx_valid, bif.overflow);
        end
        bif.rx_ready = 1'b1;
        idle(1);
        checks++;
        if (bif.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL t6_pop got %b exp 0", bif.rx_valid);
        end
        bif.rx_ready = 1'b0;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_overflow();
        test_crc_err();
        test_foreign_and_stop();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
